// File: rtl/ovl_fire_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ovl_fire_collector
// Description : Samples OVL checker fire/xfire outputs, keeps per-checker
//               saturating fire counters and logs timestamped fire events
//               into a small first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ovl_fire_collector #(
    parameter int NUM_CHK = 4,
    parameter int CNT_W   = 8,
    parameter int TS_W    = 16,
    parameter int DEPTH   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [NUM_CHK-1:0]  fire,
    input  logic [NUM_CHK-1:0]  xfire,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [3:0]          rd_id,
    output logic [1:0]          rd_kind,
    output logic [TS_W-1:0]     rd_ts,
    input  logic [3:0]          cnt_sel,
    output logic [CNT_W-1:0]    cnt_out,
    output logic                any_fire,
    output logic                overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 4 + 2 + TS_W;

    // Free-running timestamp
    logic [TS_W-1:0]    r_ts;

    // Per-checker pending slots and counters
    logic [NUM_CHK-1:0] r_pv;
    logic [1:0]         r_pkind [NUM_CHK];
    logic [TS_W-1:0]    r_pts   [NUM_CHK];
    logic [CNT_W-1:0]   r_cnt   [NUM_CHK];

    // Event FIFO storage and bookkeeping
    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW-1:0]      r_wp;
    logic [AW-1:0]      r_rp;
    logic [CW-1:0]      r_count;

    logic [NUM_CHK-1:0] w_hit;
    logic [1:0]         w_kind [NUM_CHK];
    logic               w_sel_v;
    logic [3:0]         w_sel;
    logic [EW-1:0]      w_pdata;
    logic [NUM_CHK-1:0] w_drain;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic [CW-1:0]      w_cnt_after_pop;
    logic [CW-1:0]      w_count_nxt;
    logic [AW-1:0]      w_rp_nxt;
    logic [EW-1:0]      w_head;

    // Qualify inputs: only a clean 1 counts, X/Z is treated as no fire
    always_comb begin
        for (int i = 0; i < NUM_CHK; i++) begin
            w_kind[i] = {(xfire[i] === 1'b1), (fire[i] === 1'b1)};
            w_hit[i]  = enable & (|w_kind[i]);
        end
    end

    // Pick the lowest-index pending slot as the drain candidate
    always_comb begin
        w_sel_v = 1'b0;
        w_sel   = '0;
        w_pdata = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (r_pv[i]) begin
                w_sel_v = 1'b1;
                w_sel   = 4'(i);
                w_pdata = {4'(i), r_pkind[i], r_pts[i]};
            end
        end
    end

    // FIFO push/pop decisions and the next head entry for the output registers
    always_comb begin
        w_pop           = rd_valid & rd_ready;
        w_full          = (r_count == CW'(DEPTH));
        w_push          = w_sel_v & (~w_full | w_pop);
        w_cnt_after_pop = r_count - CW'(w_pop);
        w_count_nxt     = w_cnt_after_pop + CW'(w_push);
        w_rp_nxt        = r_rp + AW'(w_pop);
        if (w_count_nxt == '0)
            w_head = '0;
        else if (w_cnt_after_pop == '0)
            w_head = w_pdata;           // entry arrives into an empty FIFO
        else
            w_head = r_mem[w_rp_nxt];
        for (int i = 0; i < NUM_CHK; i++)
            w_drain[i] = w_push & (w_sel == 4'(i));
    end

    // Counter readback mux; out-of-range selects read as zero
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < NUM_CHK; i++)
            if (cnt_sel == 4'(i))
                cnt_out = r_cnt[i];
    end

    // FIFO storage write (no reset needed, guarded by the pointers)
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wp] <= w_pdata;
    end

    // FIFO pointers, occupancy and registered head outputs
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            rd_valid <= 1'b0;
            rd_id    <= '0;
            rd_kind  <= '0;
            rd_ts    <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + AW'(1);
            r_rp                   <= w_rp_nxt;
            r_count                <= w_count_nxt;
            rd_valid               <= (w_count_nxt != '0);
            {rd_id, rd_kind, rd_ts} <= w_head;
        end
    end

    // Timestamp, pending slots, counters and sticky flags
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_ts     <= '0;
            r_pv     <= '0;
            any_fire <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CHK; i++) begin
                r_pkind[i] <= '0;
                r_pts[i]   <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            if (enable)
                r_ts <= r_ts + TS_W'(1);
            for (int i = 0; i < NUM_CHK; i++) begin
                if (w_hit[i]) begin
                    // A slot leaving this cycle reloads rather than merges
                    if (!r_pv[i] || w_drain[i]) begin
                        r_pv[i]    <= 1'b1;
                        r_pkind[i] <= w_kind[i];
                        r_pts[i]   <= r_ts;
                    end else begin
                        r_pkind[i] <= r_pkind[i] | w_kind[i];
                    end
                    if (r_cnt[i] != '1)
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_drain[i]) begin
                    r_pv[i] <= 1'b0;
                end
            end
            if (|w_hit)
                any_fire <= 1'b1;
            if (|(w_hit & r_pv & ~w_drain))
                overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire
